// File: rtl/pwm_deadtime_if.sv
// Register write bus for pwm_deadtime.
// Master drives one write per cycle that wen is high.
interface pwm_deadtime_if;
  logic       wen;
  logic [7:0] wdata;
  logic [3:0] addr;

  modport master (
    output wen,
    output wdata,
    output addr
  );

  modport slave (
    input wen,
    input wdata,
    input addr
  );
endinterface

// File: rtl/pwm_deadtime.sv
// Complementary gate driver with programmable dead time
// and a latched, synchronized fault shutdown.
module pwm_deadtime (
  input  logic          clk,
  input  logic          rst,
  pwm_deadtime_if.slave bus,
  input  logic          pwm_in,
  input  logic          fault_in,
  output logic          out_hi,
  output logic          out_lo,
  output logic          fault_flag,
  output logic          active
);

  localparam logic [2:0] S_OFF  = 3'd0;
  localparam logic [2:0] S_LO   = 3'd1;
  localparam logic [2:0] S_DTLH = 3'd2;
  localparam logic [2:0] S_HI   = 3'd3;
  localparam logic [2:0] S_DTHL = 3'd4;

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rise_q, rise_d;
  logic [7:0] fall_q, fall_d;
  logic       en_q, en_d;
  logic       flag_q, flag_d;
  logic       fs1_q, fs2_q;

  logic wr_rise, wr_fall, wr_ctrl;
  logic go_rise, go_fall;

  assign wr_rise = bus.wen && (bus.addr == 4'h0);
  assign wr_fall = bus.wen && (bus.addr == 4'h4);
  assign wr_ctrl = bus.wen && (bus.addr == 4'h8);

  always_comb begin
    rise_d = wr_rise ? bus.wdata : rise_q;
    fall_d = wr_fall ? bus.wdata : fall_q;
    en_d   = wr_ctrl ? bus.wdata[0] : en_q;
    flag_d = flag_q;
    // a live fault wins over a clear in the same cycle
    if (fs2_q)
      flag_d = 1'b1;
    else if (wr_ctrl && bus.wdata[1])
      flag_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_rise = 1'b0;
    go_fall = 1'b0;
    if (!en_q || flag_q || fs2_q) begin
      state_d = S_OFF;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_OFF: begin
          go_rise = pwm_in;
          go_fall = !pwm_in;
        end
        S_LO: go_rise = pwm_in;
        S_HI: go_fall = !pwm_in;
        S_DTLH, S_DTHL: begin
          if (cnt_q != 8'd0)
            cnt_d = cnt_q - 8'd1;
          else
            state_d = pwm_in ? S_HI : S_LO;
        end
        default: state_d = S_OFF;
      endcase
      if (go_rise) begin
        if (rise_q == 8'd0) begin
          state_d = S_HI;
        end else begin
          state_d = S_DTLH;
          cnt_d   = rise_q - 8'd1;
        end
      end
      if (go_fall) begin
        if (fall_q == 8'd0) begin
          state_d = S_LO;
        end else begin
          state_d = S_DTHL;
          cnt_d   = fall_q - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      rise_q  <= 8'd4;
      fall_q  <= 8'd4;
      en_q    <= 1'b0;
      flag_q  <= 1'b0;
      fs1_q   <= 1'b0;
      fs2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      en_q    <= en_d;
      flag_q  <= flag_d;
      fs1_q   <= fault_in;
      fs2_q   <= fs1_q;
    end
  end

  assign out_hi     = (state_q == S_HI);
  assign out_lo     = (state_q == S_LO);
  assign active     = (state_q != S_OFF);
  assign fault_flag = flag_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: directed cases with literal
// expectations plus random traffic against a gap model.
module tb_pwm_deadtime;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm_in = 1'b0;
  logic fault_in = 1'b0;
  logic out_hi, out_lo, fault_flag, active;

  pwm_deadtime_if bus ();

  pwm_deadtime dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .pwm_in     (pwm_in),
    .fault_in   (fault_in),
    .out_hi     (out_hi),
    .out_lo     (out_lo),
    .fault_flag (fault_flag),
    .active     (active)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nbad = 0;

  // model: on/off, driven side, remaining both-low cycles
  bit m_on, m_side, m_en, m_flag, m_fs1, m_fs2;
  int m_gap, m_rise, m_fall, m_lastdead;
  int last_side, lowrun;

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_side = 0; m_gap = 0;
    m_rise = 4; m_fall = 4; m_en = 0; m_flag = 0;
    m_fs1 = 0; m_fs2 = 0; m_lastdead = 0;
    last_side = -1; lowrun = 0;
  endtask

  task automatic model_step();
    bit wr, nflag, nen;
    int nrise, nfall, d;
    wr    = bus.wen && (bus.addr == 4'h8);
    nflag = m_fs2 ? 1'b1 : (wr && bus.wdata[1]) ? 1'b0 : m_flag;
    nen   = wr ? bus.wdata[0] : m_en;
    nrise = (bus.wen && bus.addr == 4'h0) ? int'(bus.wdata) : m_rise;
    nfall = (bus.wen && bus.addr == 4'h4) ? int'(bus.wdata) : m_fall;
    if (!m_en || m_flag || m_fs2) begin
      m_on = 0;
    end else if (!m_on || (m_gap == 0 && pwm_in != m_side)) begin
      d = pwm_in ? m_rise : m_fall;
      m_on = 1; m_side = pwm_in; m_gap = d; m_lastdead = d;
    end else if (m_gap == 1) begin
      m_gap = 0; m_side = pwm_in;
    end else if (m_gap > 1) begin
      m_gap--;
    end
    m_fs2 = m_fs1; m_fs1 = fault_in;
    m_flag = nflag; m_en = nen; m_rise = nrise; m_fall = nfall;
  endtask

  always @(posedge clk) begin
    bit e_hi, e_lo;
    if (rst) model_reset();
    else model_step();
    #1;
    if (!rst) begin
      e_hi = m_on && m_gap == 0 && m_side;
      e_lo = m_on && m_gap == 0 && !m_side;
      chk("out_hi", out_hi, e_hi);
      chk("out_lo", out_lo, e_lo);
      chk("active", active, m_on);
      chk("fault_flag", fault_flag, m_flag);
      chk("exclusive", out_hi & out_lo, 0);
      if (out_hi || out_lo) begin
        if (last_side >= 0 && last_side != int'(out_hi)) begin
          ncmp++;
          if (lowrun < m_lastdead) begin
            nbad++;
            $display("FAIL gap at %0t: got %0d expected >= %0d",
                     $time, lowrun, m_lastdead);
          end
        end
        last_side = int'(out_hi);
        lowrun = 0;
      end else begin
        lowrun++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(logic [3:0] a, logic [7:0] d);
    bus.wen = 1'b1; bus.addr = a; bus.wdata = d;
    tick();
    bus.wen = 1'b0;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int pwm_left, fault_left, r;
    logic [3:0] ga;
    bus.wen = 1'b0; bus.addr = '0; bus.wdata = '0;
    #1;
    chk("rst_async_hi", out_hi, 0);
    chk("rst_async_act", active, 0);
    ticks(2);
    rst = 1'b0;
    tick();
    chk("reset_hi", out_hi, 0);
    chk("reset_lo", out_lo, 0);
    chk("reset_active", active, 0);
    chk("reset_flag", fault_flag, 0);

    // enable with pwm low: 4 both-low cycles then LO
    wr(4'h8, 8'h01);
    ticks(4);
    chk("en_dt_lo", out_lo, 0);
    chk("en_dt_active", active, 1);
    tick();
    chk("en_lo", out_lo, 1);

    // dead_rise=3, dead_fall=0
    wr(4'h0, 8'd3);
    wr(4'h4, 8'd0);
    pwm_in = 1'b1;
    tick();
    chk("rise_lo_fall", out_lo, 0);
    ticks(2);
    chk("rise_hi_wait", out_hi, 0);
    tick();
    chk("rise_hi", out_hi, 1);
    pwm_in = 1'b0;
    tick();
    chk("swap_hi", out_hi, 0);
    chk("swap_lo", out_lo, 1);

    // back to HI, then a 2-cycle low pulse with dead_fall=5
    wr(4'h4, 8'd5);
    pwm_in = 1'b1;
    ticks(4);
    chk("hi_again", out_hi, 1);
    pwm_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) pwm_in = 1'b1;
      tick();
      chk("pulse_both_low", out_hi | out_lo, 0);
    end
    tick();
    chk("pulse_hi", out_hi, 1);

    // fault while HI
    fault_in = 1'b1;
    ticks(3);
    chk("fault_hi", out_hi, 0);
    chk("fault_flag_set", fault_flag, 1);
    wr(4'h8, 8'h03);
    chk("fault_clr_held", fault_flag, 1);
    fault_in = 1'b0;
    ticks(2);
    wr(4'h8, 8'h03);
    chk("fault_clr", fault_flag, 0);
    ticks(3);
    chk("resume_dt", out_hi, 0);
    chk("resume_act", active, 1);
    tick();
    chk("resume_hi", out_hi, 1);

    // disable mid DT_LH
    pwm_in = 1'b0;
    ticks(6);
    chk("to_lo", out_lo, 1);
    pwm_in = 1'b1;
    tick();
    wr(4'h8, 8'h00);
    chk("dis_still_dt", active, 1);
    tick();
    chk("dis_off", active, 0);
    wr(4'h8, 8'h01);
    ticks(4);
    chk("reen_hi", out_hi, 1);

    // asynchronous reset while HI
    #3;
    rst = 1'b1;
    #1;
    chk("arst_hi", out_hi, 0);
    chk("arst_lo", out_lo, 0);
    chk("arst_act", active, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    wr(4'h8, 8'h01);
    ticks(4);
    chk("rst_rise4_wait", out_hi, 0);
    tick();
    chk("rst_rise4", out_hi, 1);
    pwm_in = 1'b0;
    ticks(4);
    chk("rst_fall4_wait", out_lo, 0);
    tick();
    chk("rst_fall4", out_lo, 1);

    // random traffic
    pwm_left = 0;
    fault_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (pwm_left == 0) begin
        pwm_in = ~pwm_in;
        pwm_left = $urandom_range(1, 12);
      end
      pwm_left--;
      r = $urandom_range(0, 99);
      bus.wen = 1'b0;
      if (r < 4) begin
        bus.wen = 1'b1;
        bus.addr = (r < 2) ? 4'h0 : 4'h4;
        bus.wdata = 8'($urandom_range(0, 7));
      end else if (r < 7) begin
        bus.wen = 1'b1;
        bus.addr = 4'h8;
        bus.wdata = {6'd0, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 9) != 0)};
      end else if (r < 8) begin
        ga = 4'($urandom_range(0, 15)) | 4'h1;
        bus.wen = 1'b1;
        bus.addr = ga;
        bus.wdata = 8'($urandom_range(0, 255));
      end
      if (fault_left > 0) begin
        fault_in = 1'b1;
        fault_left--;
      end else begin
        fault_in = 1'b0;
        if ($urandom_range(0, 299) == 0)
          fault_left = $urandom_range(1, 6);
      end
      tick();
    end
    bus.wen = 1'b0;
    ticks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime.md
PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 SHALL have port clk, input, 1: system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port wen, input, 1: register write strobe, one write per asserted cycle.
REQ-004 SHALL have port wdata, input, 8: register write data.
REQ-005 SHALL have port addr, input, 4: register select; 0x0 dead_rise, 0x4 dead_fall, 0x8 ctrl, others ignored.
REQ-006 SHALL have port pwm_in, input, 1: PWM waveform from the upstream generator, same clock domain, sampled directly.
REQ-007 SHALL have port fault_in, input, 1: asynchronous external fault, active-high.
REQ-008 SHALL have port out_hi, output, 1: high-side gate drive.
REQ-009 SHALL have port out_lo, output, 1: low-side gate drive.
REQ-010 SHALL have port fault_flag, output, 1: latched fault status.
REQ-011 SHALL have port active, output, 1: high when state is not OFF.
REQ-012 SHALL have register dead_rise, 8 bits, reset 4: number of cycles both outputs are low before out_hi rises.
REQ-013 SHALL have register dead_fall, 8 bits, reset 4: number of cycles both outputs are low before out_lo rises.
REQ-014 SHALL have ctrl fields enable (wdata[0], reset 0) and fault_clr (wdata[1], write-1 pulse, not stored).

Function
REQ-015 SHALL implement states OFF, LO, DT_LH, HI, DT_HL plus an 8-bit down-counter cnt.
REQ-016 SHALL decode outputs from state only: out_hi=(HI), out_lo=(LO), both 0 in OFF/DT_LH/DT_HL; out_hi and out_lo never simultaneously 1.
REQ-017 SHALL, when enable=0 or fault_flag=1, go to OFF at the next edge from any state, with cnt cleared.
REQ-018 SHALL, in OFF with enable=1 and fault_flag=0, go toward the level of pwm_in: if pwm_in=1, use dead_rise (DT_LH path); else use dead_fall (DT_HL path).
REQ-019 SHALL, in LO with pwm_in=1, go to DT_LH with cnt=dead_rise-1, or directly to HI if dead_rise=0.
REQ-020 SHALL, in HI with pwm_in=0, go to DT_HL with cnt=dead_fall-1, or directly to LO if dead_fall=0.
REQ-021 SHALL, in DT_LH/DT_HL, decrement cnt while cnt!=0, and at cnt=0 go to HI if pwm_in=1, else LO; both-low time is exactly D cycles for dead value D>=1.
REQ-022 SHALL, when pwm_in toggles back during a dead interval, complete the interval and then select the exit state from pwm_in at cnt=0; no interval restart.
REQ-023 SHALL give latency for pwm_in rise after edge 0: out_lo falls at edge 1 and out_hi rises at edge D+1 (D=dead_rise); falling edge is symmetric with dead_fall.
REQ-024 SHALL apply writes to dead_rise/dead_fall at the next dead-interval entry; a running count is unaffected.
REQ-025 SHALL pass fault_in through a two-flop synchronizer (fs1, fs2).
REQ-026 SHALL set fault_flag at the edge where fs2=1 is sampled, and force state OFF at that same edge.
REQ-027 SHALL clear fault_flag on a ctrl write with wdata[1]=1 only if fs2=0; the set condition dominates a simultaneous clear.
REQ-028 SHALL make a ctrl write update enable regardless of fault state; outputs resume per REQ-018 only once fault_flag=0.

Reset
REQ-029 SHALL, on rst asserted, immediately set: state OFF, cnt 0, dead_rise 4, dead_fall 4, enable 0, fs1/fs2 0, fault_flag 0; therefore out_hi=out_lo=0, active=0.
REQ-030 SHALL, on rst mid-operation, drive both outputs to 0 without waiting for a clock edge.

Verification
REQ-031 SHALL cover: after reset, write ctrl=0x01 with pwm_in=0 -> both outputs low for 4 cycles, then out_lo=1, active=1.
REQ-032 SHALL cover: dead_rise=3, pwm_in rises -> out_lo falls 1 cycle later, out_hi rises 4 cycles later (3 both-low cycles); dead_fall=0, pwm_in falls -> out_hi and out_lo swap at the same edge.
REQ-033 SHALL cover: dead_fall=5, pwm_in 1->0->1 pulse of 2 cycles -> 5 both-low cycles, then HI; out_lo never asserts.
REQ-034 SHALL cover: fault_in pulse while HI -> outputs 0 by 3rd edge, fault_flag=1; clear write with fault_in still high -> flag stays 1; clear after release -> flag 0, outputs resume through dead interval.
REQ-035 SHALL cover: enable=0 written mid DT_LH -> OFF next edge; rst asserted while HI -> outputs 0 asynchronously, registers at reset values.
REQ-036 SHALL cover, with random pwm_in, dead values and faults, the assertion that out_hi and out_lo are never 1 together and that each both-low gap between opposite-side assertions is at least the programmed dead value.
